cfg_gate_array: RTL and testbench
=================================

# cfg_gate_array

Runtime-configurable array of 2-input logic lanes: the parametrised successor of our fixed inverter/OR/mux TinyTapeout cells. Each lane applies a serially loaded 3-bit opcode to its operand pair and drives a registered output. A saturating rising-edge counter observes one selectable lane. It sits between the `ui_in`/`uio_in` pins and `uo_out` in a `tt_um_*` wrapper.

## Interface
- `CHANNELS`, 4: number of lanes (1..8)
- `COUNT_W`, 8: edge counter width (2..16)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `din`  in  2*CHANNELS  lane i operands: a=`din[2i]`, b=`din[2i+1]`
- `mux_sel`  in  1  global select for MUX opcode
- `cfg_shift`  in  1  shift `cfg_bit` into shadow config
- `cfg_bit`  in  1  serial config data
- `cfg_commit`  in  1  copy shadow to active config
- `cnt_sel`  in  $clog2(CHANNELS) (min 1)  lane observed by counter
- `cnt_clr`  in  1  synchronous counter clear
- `dout`  out  CHANNELS  registered lane results
- `cnt`  out  COUNT_W  saturating rising-edge count of `dout[cnt_sel]`
- `cfg_active`  out  3*CHANNELS  active opcodes, lane i at bits [3i+2:3i]

## Operation
- Opcodes: 000 PASS_A, 001 NOT_A, 010 AND, 011 OR, 100 XOR, 101 MUX (`mux_sel` ? a : b), 110 NAND, 111 NOR.
- Shadow: when `cfg_shift`=1, shadow <= {shadow[3*CHANNELS-2:0], `cfg_bit`}. The first bit shifted ends at the MSB after 3*CHANNELS shifts.
- `cfg_commit`=1: active <= shadow value from before this edge. A simultaneous shift still updates the shadow.
- Each lane registers op(a,b) into `dout[i]` every cycle. The output is never gated.
- Counter:
  - `prev` holds the last sampled `dout[cnt_sel]`.
  - Rising edge (prev=0, current=1) increments `cnt`.
  - `cnt` holds at 2^COUNT_W-1; no wrap.
  - `cnt_clr` forces 0 and beats a simultaneous edge.
  - A change of `cnt_sel` clears `cnt` to 0, reloads `prev` from the new lane, and counts nothing that cycle.
- Reset: shadow=0, active=0 (all PASS_A), `dout`=0, `cnt`=0, `prev`=0, `cnt_sel` tracking register=0. Assertion mid-operation takes effect immediately and discards partial shifts.

## Timing
- `din`/`mux_sel` to `dout`: 1 cycle (3 with sync feature).
- `cfg_commit` sampled at edge k: the new opcode first affects `dout` at edge k+1.
- `dout[cnt_sel]` rises at edge t: `cnt` increments at edge t+1.
- `cnt_clr` at edge k: `cnt`=0 after edge k.
- All outputs are flop-driven; no combinational input-to-output path.

## Configuration
- `CFG_GATE_SYNC_EN` defined: `din` and `mux_sel` pass through 2-flop synchronisers (reset 0) before the lanes. Pin-to-`dout` latency is 3 cycles.
- Undefined: inputs are used directly. Latency is 1 cycle.
- Config and counter paths are unchanged in both builds.

## Structure
- `cfg_gate_pkg`: opcode enum `gate_op_e` (3 bits), `OP_W`=3, and the opcode encoding constants.
- Sub-module `cfg_gate_lane`: opcode decode plus output flop, instantiated CHANNELS times.
- Top level: shadow/active registers, optional synchronisers, edge counter.

## Test plan
- Reset mid-stream:
  - Stimulus: shift 5 bits, set `dout`=0xF, `cnt`=7, then pulse `rst_n` low.
  - Response: `dout`=0, `cnt`=0, `cfg_active`=0 asynchronously. A fresh 12-bit load then works.
- Config load (CHANNELS=4):
  - Stimulus: shift 100_101_001_010 MSB-first and commit, giving `cfg_active`=0x94A. Then `din`=0xB6, `mux_sel`=0.
  - Response: `dout`=0xC one cycle later.
- Commit/shift collision:
  - Stimulus: shadow=0x94A; assert `cfg_commit` and `cfg_shift` (`cfg_bit`=1) in the same cycle.
  - Response: `cfg_active`=0x94A, shadow=0x295.
- Counting:
  - Stimulus: PASS_A everywhere, `cnt_sel`=0, toggle `din[0]` 0→1 five times.
  - Response: `cnt`=5. Switch `cnt_sel` to 1: `cnt`=0 next cycle.
- Saturation and clear:
  - Stimulus: COUNT_W=4, apply 20 rising edges.
  - Response: `cnt`=15 and holds. Assert `cnt_clr` coincident with an edge: `cnt`=0.
- Sync build:
  - Stimulus: with `CFG_GATE_SYNC_EN`, step `din[0]` 0→1 at edge k.
  - Response: `dout[0]`=1 after edge k+3, not before.

Source files
------------

// File: rtl/cfg_gate_pkg.sv
// Shared opcode definitions for the configurable gate array.
// Lanes evaluate one of eight 2-input functions selected by a 3-bit opcode.
package cfg_gate_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PASS_A = 3'b000,
        OP_NOT_A  = 3'b001,
        OP_AND    = 3'b010,
        OP_OR     = 3'b011,
        OP_XOR    = 3'b100,
        OP_MUX    = 3'b101,
        OP_NAND   = 3'b110,
        OP_NOR    = 3'b111
    } gate_op_e;

    function automatic logic apply_op(input gate_op_e op, input logic a,
                                      input logic b, input logic sel);
        logic r;
        case (op)
            OP_PASS_A: r = a;
            OP_NOT_A:  r = ~a;
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_MUX:    r = sel ? a : b;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            default:   r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cfg_gate_lane.sv
// One logic lane: decodes its opcode and registers the result every cycle.
module cfg_gate_lane
    import cfg_gate_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            a,
    input  logic            b,
    input  logic            mux_sel,
    output logic            q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= apply_op(gate_op_e'(op), a, b, mux_sel);
        end
    end

endmodule

// File: rtl/cfg_gate_array.sv
// Serially configured array of gate lanes with a saturating rising-edge counter.
// Define CFG_GATE_SYNC_EN to pass din/mux_sel through 2-flop synchronisers.
module cfg_gate_array
    import cfg_gate_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int COUNT_W  = 8,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2*CHANNELS-1:0]    din,
    input  logic                     mux_sel,
    input  logic                     cfg_shift,
    input  logic                     cfg_bit,
    input  logic                     cfg_commit,
    input  logic [SEL_W-1:0]         cnt_sel,
    input  logic                     cnt_clr,
    output logic [CHANNELS-1:0]      dout,
    output logic [COUNT_W-1:0]       cnt,
    output logic [OP_W*CHANNELS-1:0] cfg_active
);

    localparam int CFG_W = OP_W * CHANNELS;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [CFG_W-1:0]      shadow;
    logic [2*CHANNELS-1:0] lane_din;
    logic                  lane_mux_sel;
    logic [SEL_W-1:0]      sel_q;
    logic                  prev;
    logic                  cur;

    // Commit copies the pre-edge shadow, so a coincident shift never leaks into active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            cfg_active <= '0;
        end else begin
            if (cfg_shift) begin
                shadow <= {shadow[CFG_W-2:0], cfg_bit};
            end
            if (cfg_commit) begin
                cfg_active <= shadow;
            end
        end
    end

`ifdef CFG_GATE_SYNC_EN
    logic [2*CHANNELS-1:0] din_meta;
    logic [2*CHANNELS-1:0] din_sync;
    logic                  mux_meta;
    logic                  mux_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_meta <= '0;
            din_sync <= '0;
            mux_meta <= 1'b0;
            mux_sync <= 1'b0;
        end else begin
            din_meta <= din;
            din_sync <= din_meta;
            mux_meta <= mux_sel;
            mux_sync <= mux_meta;
        end
    end

    assign lane_din     = din_sync;
    assign lane_mux_sel = mux_sync;
`else
    assign lane_din     = din;
    assign lane_mux_sel = mux_sel;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        cfg_gate_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .op      (cfg_active[OP_W*i +: OP_W]),
            .a       (lane_din[2*i]),
            .b       (lane_din[2*i+1]),
            .mux_sel (lane_mux_sel),
            .q       (dout[i])
        );
    end

    // Out-of-range selects (non power-of-two CHANNELS) observe a constant 0.
    always_comb begin
        cur = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cnt_sel == SEL_W'(i)) begin
                cur = dout[i];
            end
        end
    end

    // A lane switch restarts from zero with prev reloaded from the new lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            prev  <= 1'b0;
            sel_q <= '0;
        end else begin
            sel_q <= cnt_sel;
            prev  <= cur;
            if (cnt_sel != sel_q || cnt_clr) begin
                cnt <= '0;
            end else if (!prev && cur && cnt != CNT_MAX) begin
                cnt <= cnt + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cfg_gate_array.sv
// Directed bench for cfg_gate_array (CHANNELS=4, COUNT_W=4); adapts to CFG_GATE_SYNC_EN.
module tb_cfg_gate_array;

`ifdef CFG_GATE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = '0;
    logic        mux_sel = 1'b0;
    logic        cfg_shift = 1'b0;
    logic        cfg_bit = 1'b0;
    logic        cfg_commit = 1'b0;
    logic [1:0]  cnt_sel = '0;
    logic        cnt_clr = 1'b0;
    logic [3:0]  dout;
    logic [3:0]  cnt;
    logic [11:0] cfg_active;

    int total = 0;
    int bad = 0;

    cfg_gate_array #(.CHANNELS(4), .COUNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .mux_sel    (mux_sel),
        .cfg_shift  (cfg_shift),
        .cfg_bit    (cfg_bit),
        .cfg_commit (cfg_commit),
        .cnt_sel    (cnt_sel),
        .cnt_clr    (cnt_clr),
        .dout       (dout),
        .cnt        (cnt),
        .cfg_active (cfg_active)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] d, input logic sh, input logic bt,
                                 input logic cm, input logic cl);
        din        = d;
        cfg_shift  = sh;
        cfg_bit    = bt;
        cfg_commit = cm;
        cnt_clr    = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadConfig(input logic [7:0] d, input logic [11:0] word);
        for (int i = 11; i >= 0; i--) begin
            applyStimulus(d, 1'b1, word[i], 1'b0, 1'b0);
        end
    endtask

    task automatic toggleLane0(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(8'h54, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        repeat (LAT + 1) applyStimulus(8'h54, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        $display("[TB] start, input latency %0d", LAT);
        @(posedge clk);
        #1;
        checkOutput("reset_dout", 16'(dout), 16'h0);
        checkOutput("reset_cnt", 16'(cnt), 16'h0);
        checkOutput("reset_active", 16'(cfg_active), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load XOR/MUX/NOT_A/AND; dout stays PASS_A until the commit edge has passed.
        loadConfig(8'hB6, 12'h94A);
        checkOutput("pre_commit_dout", 16'(dout), 16'h6);
        applyStimulus(8'hB6, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("commit_active", 16'(cfg_active), 16'h94A);
        checkOutput("commit_edge_dout", 16'(dout), 16'h6);
        applyStimulus(8'hB6, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cfg_load_dout", 16'(dout), 16'hC);

        mux_sel = 1'b1;
        repeat (LAT) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pattern_00_sel1", 16'(dout), 16'h2);
        mux_sel = 1'b0;
        repeat (LAT) applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pattern_ff_sel0", 16'(dout), 16'h5);

        // Commit and shift together: active gets the old shadow, shadow still shifts.
        applyStimulus(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("collision_active", 16'(cfg_active), 16'h94A);
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("collision_shadow", 16'(cfg_active), 16'h295);

        loadConfig(8'h96, 12'hDD8);
        applyStimulus(8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("nand_nor_or_active", 16'(cfg_active), 16'hDD8);
        applyStimulus(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("nand_nor_or_dout", 16'(dout), 16'hA);

        // Lane 0 PASS_A, lanes 1..3 OR, used for latency and counting.
        loadConfig(8'h54, 12'h6D8);
        applyStimulus(8'h54, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (LAT + 1) applyStimulus(8'h54, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("or_lanes_dout", 16'(dout), 16'hE);

        for (int i = 1; i <= LAT; i++) begin
            applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("latency_dout0", 16'(dout[0]), 16'(i == LAT));
        end
        repeat (LAT + 1) applyStimulus(8'h54, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h54, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clear_cnt", 16'(cnt), 16'h0);

        toggleLane0(5);
        checkOutput("count_five", 16'(cnt), 16'h5);
        cnt_sel = 2'd1;
        applyStimulus(8'h54, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sel_change_clears", 16'(cnt), 16'h0);
        applyStimulus(8'h54, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sel_new_lane_hold", 16'(cnt), 16'h0);
        cnt_sel = 2'd0;
        applyStimulus(8'h54, 1'b0, 1'b0, 1'b0, 1'b0);

        toggleLane0(20);
        checkOutput("saturate", 16'(cnt), 16'hF);
        toggleLane0(2);
        checkOutput("saturate_hold", 16'(cnt), 16'hF);
        repeat (LAT) applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_beats_edge", 16'(cnt), 16'h0);

        // Reach dout=F, cnt=7 with a partial shift pending, then reset mid-cycle.
        repeat (LAT + 1) applyStimulus(8'h54, 1'b0, 1'b0, 1'b0, 1'b0);
        toggleLane0(6);
        repeat (5) applyStimulus(8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (LAT + 1) applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("prereset_dout", 16'(dout), 16'hF);
        checkOutput("prereset_cnt", 16'(cnt), 16'h7);
        checkOutput("prereset_active", 16'(cfg_active), 16'h6D8);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_dout", 16'(dout), 16'h0);
        checkOutput("async_reset_cnt", 16'(cnt), 16'h0);
        checkOutput("async_reset_active", 16'(cfg_active), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'hB6, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("shadow_discarded", 16'(cfg_active), 16'h0);
        loadConfig(8'hB6, 12'h94A);
        applyStimulus(8'hB6, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("reload_active", 16'(cfg_active), 16'h94A);
        applyStimulus(8'hB6, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reload_dout", 16'(dout), 16'hC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
